// File: rtl/mcycle_pkg.sv
// Shared definitions for the multi-cycle unit scheduler: state encoding,
// default widths and the grant-index width helper.
package mcycle_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t ISSUE = 2'd1;
    localparam state_t WAIT  = 2'd2;
    localparam state_t RESP  = 2'd3;

    localparam int DEF_OPW = 1;
    localparam int DEF_DW  = 32;

    // Index width for 2..4 requesters; never zero so a 2-way pick still has a bit.
    function automatic int idx_w(input int n);
        return (n > 2) ? 2 : 1;
    endfunction

endpackage

// File: rtl/mcycle_sched_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from ptr
// with wrap-around. Also usable by the hazard unit.
module rr_pick
    import mcycle_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   idx,
    output logic            any
);

    localparam logic [IW:0] NREQ_W = NREQ[IW:0];

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [IW-1:0]     w_off;
    logic [IW:0]       w_sum;

    // Rotating a doubled vector puts requester ptr at bit 0, so the lowest
    // set bit of w_rot is the winner's distance from ptr.
    assign w_dbl = {req, req};
    assign w_rot = NREQ'(w_dbl >> ptr);

    always_comb begin
        w_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IW'(k);
            end
        end
    end

    assign w_sum = {1'b0, ptr} + {1'b0, w_off};
    assign idx   = IW'((w_sum >= NREQ_W) ? (w_sum - NREQ_W) : w_sum);
    assign any   = |req;

endmodule

// File: rtl/mcycle_sched.sv
// Round-robin scheduler sharing one iterative multi-cycle unit between NREQ
// requesters. Optional WAIT watchdog enabled by defining MCS_TIMEOUT_EN.
module mcycle_sched
    import mcycle_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int OPW         = DEF_OPW,
    parameter int DW          = DEF_DW,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*OPW-1:0] op,
    input  logic [NREQ*DW-1:0]  opa,
    input  logic [NREQ*DW-1:0]  opb,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic [DW-1:0]       result,
    output logic                err,
    output logic                spurious,
    output logic                u_start,
    output logic [OPW-1:0]      u_op,
    output logic [DW-1:0]       u_opa,
    output logic [DW-1:0]       u_opb,
    output logic                u_abort,
    input  logic                u_busy,
    input  logic                u_done,
    input  logic [DW-1:0]       u_result
);

    localparam int IW = idx_w(NREQ);

    state_t          r_state;
    state_t          w_state_next;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   w_pick_idx;
    logic            w_pick_any;
    logic [NREQ-1:0] w_idx_oh;
    logic            r_spurious;
    logic [DW-1:0]   r_result;
    logic [OPW-1:0]  r_op;
    logic [DW-1:0]   r_opa;
    logic [DW-1:0]   r_opb;
    logic            w_timeout;
    logic            w_unused;

    logic [OPW-1:0]  w_op_arr  [NREQ];
    logic [DW-1:0]   w_opa_arr [NREQ];
    logic [DW-1:0]   w_opb_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign w_op_arr[gi]  = op[gi*OPW +: OPW];
            assign w_opa_arr[gi] = opa[gi*DW +: DW];
            assign w_opb_arr[gi] = opb[gi*DW +: DW];
            assign w_idx_oh[gi]  = (r_idx == IW'(gi));
        end
    endgenerate

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req (req),
        .ptr (r_ptr),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    // The unit's busy flag is informational; sequencing relies on the FSM alone.
    assign w_unused = &{1'b0, u_busy, (TIMEOUT_CYC > 0)};

`ifdef MCS_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0] r_to_cnt;
    logic          r_err_flag;

    // Counter sits at zero outside WAIT, so it is cleared on every WAIT entry.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_to_cnt   <= '0;
            r_err_flag <= 1'b0;
        end else begin
            r_to_cnt <= (r_state == WAIT) ? r_to_cnt + 1'b1 : '0;
            if (r_state == WAIT) begin
                r_err_flag <= w_timeout;
            end
        end
    end

    // A completion arriving on the expiry cycle takes priority over the abort.
    assign w_timeout = (r_state == WAIT) && !u_done && (r_to_cnt == CW'(TIMEOUT_CYC - 1));
    assign err       = (r_state == RESP) && r_err_flag;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    assign u_abort = w_timeout;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_pick_any) w_state_next = ISSUE;
            ISSUE:   w_state_next = WAIT;
            WAIT:    if (u_done || w_timeout) w_state_next = RESP;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        gnt     = '0;
        done    = '0;
        u_start = 1'b0;
        if (r_state != IDLE) begin
            gnt = w_idx_oh;
        end
        if (r_state == ISSUE) begin
            u_start = 1'b1;
        end
        if (r_state == RESP) begin
            done = w_idx_oh;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_ptr      <= '0;
            r_idx      <= '0;
            r_op       <= '0;
            r_opa      <= '0;
            r_opb      <= '0;
            r_result   <= '0;
            r_spurious <= 1'b0;
        end else begin
            if (u_done && (r_state != WAIT)) begin
                r_spurious <= 1'b1;
            end
            if ((r_state == IDLE) && w_pick_any) begin
                r_idx <= w_pick_idx;
                r_op  <= w_op_arr[w_pick_idx];
                r_opa <= w_opa_arr[w_pick_idx];
                r_opb <= w_opb_arr[w_pick_idx];
            end
            if (r_state == WAIT) begin
                if (u_done) begin
                    r_result <= u_result;
                end else if (w_timeout) begin
                    r_result <= '0;
                end
            end
            if (r_state == RESP) begin
                r_ptr <= (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + 1'b1;
            end
        end
    end

    assign result   = r_result;
    assign spurious = r_spurious;
    assign u_op     = r_op;
    assign u_opa    = r_opa;
    assign u_opb    = r_opb;

endmodule

// File: tb/tb_mcycle_sched.sv
// Scoreboard bench for mcycle_sched: directed requests push expected responses,
// a monitor pops and compares on every done pulse. Define MCS_TIMEOUT_EN for the watchdog cases.
module tb_mcycle_sched;

    localparam int NREQ = 2;
    localparam int OPW  = 1;
    localparam int DW   = 32;
    localparam int TO   = 8;

    logic                CLK = 1'b0;
    logic                Reset;
    logic [NREQ-1:0]     req;
    logic [NREQ*OPW-1:0] op;
    logic [NREQ*DW-1:0]  opa;
    logic [NREQ*DW-1:0]  opb;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     done;
    logic [DW-1:0]       result;
    logic                err;
    logic                spurious;
    logic                u_start;
    logic [OPW-1:0]      u_op;
    logic [DW-1:0]       u_opa;
    logic [DW-1:0]       u_opb;
    logic                u_abort;
    logic                u_busy;
    logic                u_done;
    logic [DW-1:0]       u_result;

    typedef struct {
        int          idx;
        logic [31:0] res;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_chk = 0;
    int          n_fail = 0;
    int          unit_lat = 3;
    bit          unit_silent = 1'b0;
    logic [31:0] unit_res;

    mcycle_sched #(
        .NREQ        (NREQ),
        .OPW         (OPW),
        .DW          (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .req      (req),
        .op       (op),
        .opa      (opa),
        .opb      (opb),
        .gnt      (gnt),
        .done     (done),
        .result   (result),
        .err      (err),
        .spurious (spurious),
        .u_start  (u_start),
        .u_op     (u_op),
        .u_opa    (u_opa),
        .u_opb    (u_opb),
        .u_abort  (u_abort),
        .u_busy   (u_busy),
        .u_done   (u_done),
        .u_result (u_result)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [OPW-1:0] o, input logic [31:0] a, input logic [31:0] b);
        op[i*OPW +: OPW] = o;
        opa[i*DW +: DW]  = a;
        opb[i*DW +: DW]  = b;
        req[i]           = 1'b1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        req   = '0;
        repeat (2) @(negedge CLK);
        Reset = 1'b0;
    endtask

    task automatic wait_done(input int i);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 64 && !seen; c++) begin
            @(negedge CLK);
            if (done[i]) begin
                seen   = 1'b1;
                req[i] = 1'b0;
            end
        end
        check("done_within_bound", seen, 1);
    endtask

    // Unit model: op 1 multiplies, op 0 adds; u_done is held for exactly cycle start+lat.
    initial begin
        u_done   = 1'b0;
        u_result = '0;
        u_busy   = 1'b0;
        forever begin
            @(negedge CLK);
            if (u_start && !unit_silent) begin
                u_busy   = 1'b1;
                unit_res = u_op[0] ? u_opa * u_opb : u_opa + u_opb;
                repeat (unit_lat) @(posedge CLK);
                #1;
                u_done   = 1'b1;
                u_result = unit_res;
                @(posedge CLK);
                #1;
                u_done   = 1'b0;
                u_busy   = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (!Reset && (done != '0)) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    mon_e = sb.pop_front();
                    $display("txn: done=%b result=%0d err=%b (expect idx %0d result %0d err %b)",
                             done, result, err, mon_e.idx, mon_e.res, mon_e.err);
                    check("done_onehot", done, 64'(1 << mon_e.idx));
                    check("result", result, mon_e.res);
                    check("err", err, mon_e.err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int  gcount;
        int  nd;
        bit  flag;

        Reset = 1'b1;
        req   = '0;
        op    = '0;
        opa   = '0;
        opb   = '0;
        do_reset();
        @(negedge CLK);
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_err", err, 0);
        check("rst_spurious", spurious, 0);
        check("rst_u_start", u_start, 0);
        check("rst_u_op", u_op, 0);
        check("rst_u_opa", u_opa, 0);
        check("rst_u_opb", u_opb, 0);
        check("rst_u_abort", u_abort, 0);

        // Single requester 0: 7*6 with 3-cycle unit latency.
        unit_lat = 3;
        sb.push_back('{0, 32'd42, 1'b0});
        set_req(0, 1'b1, 32'd7, 32'd6);
        @(negedge CLK);
        check("t1_u_start", u_start, 1);
        check("t1_gnt", gnt, 2'b01);
        check("t1_u_op", u_op, 1);
        check("t1_u_opa", u_opa, 7);
        check("t1_u_opb", u_opb, 6);
        gcount = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (done[0]) req[0] = 1'b0;
            if (gnt[0]) gcount++;
            else break;
        end
        check("t1_gnt_cycles", gcount, 5);

        // Requester 1 drops req during WAIT; operation must still complete.
        sb.push_back('{1, 32'd123, 1'b0});
        set_req(1, 1'b0, 32'd100, 32'd23);
        @(negedge CLK);
        check("t3_gnt", gnt, 2'b10);
        @(negedge CLK);
        req[1] = 1'b0;
        wait_done(1);

        // Both held: grants alternate 0,1,0,1 starting from requester 0.
        unit_lat = 2;
        sb.push_back('{0, 32'd15, 1'b0});
        sb.push_back('{1, 32'd13, 1'b0});
        sb.push_back('{0, 32'd15, 1'b0});
        sb.push_back('{1, 32'd13, 1'b0});
        set_req(0, 1'b1, 32'd3, 32'd5);
        set_req(1, 1'b0, 32'd9, 32'd4);
        nd = 0;
        for (int c = 0; c < 200 && nd < 4; c++) begin
            @(negedge CLK);
            if (done != '0) begin
                nd++;
                if (nd == 4) req = '0;
            end
        end
        check("t2_ops", nd, 4);

        // Stray u_done while idle.
        repeat (2) @(negedge CLK);
        check("t6_spurious_before", spurious, 0);
        u_done   = 1'b1;
        u_result = 32'd99;
        @(negedge CLK);
        u_done = 1'b0;
        @(negedge CLK);
        check("t6_spurious", spurious, 1);
        check("t6_gnt", gnt, 0);
        check("t6_u_start", u_start, 0);

        // Reset in WAIT, then a late u_done.
        do_reset();
        check("t4_spurious_cleared", spurious, 0);
        unit_silent = 1'b1;
        set_req(0, 1'b1, 32'd11, 32'd11);
        @(negedge CLK);
        check("t4_u_start", u_start, 1);
        @(negedge CLK);
        Reset = 1'b1;
        req   = '0;
        @(negedge CLK);
        Reset  = 1'b0;
        u_done = 1'b1;
        @(negedge CLK);
        u_done = 1'b0;
        flag   = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            if (u_start || (done != '0)) flag = 1'b1;
        end
        check("t4_no_restart_or_done", flag, 0);
        check("t4_spurious", spurious, 1);
        check("t4_gnt", gnt, 0);
        check("t4_result", result, 0);
        check("t4_u_op", u_op, 0);
        check("t4_u_opa", u_opa, 0);
        check("t4_u_opb", u_opb, 0);
        check("t4_err", err, 0);

`ifdef MCS_TIMEOUT_EN
        // Silent unit: abort on the 8th WAIT cycle, then done with err and zero result.
        do_reset();
        unit_silent = 1'b1;
        sb.push_back('{0, 32'd0, 1'b1});
        set_req(0, 1'b1, 32'd2, 32'd2);
        @(negedge CLK);
        check("t5_u_start", u_start, 1);
        nd = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge CLK);
            if (u_abort) begin
                nd = c;
                break;
            end
        end
        check("t5_abort_cycle", nd, TO);
        @(negedge CLK);
        check("t5_abort_one_cycle", u_abort, 0);
        check("t5_done", done, 2'b01);
        req[0] = 1'b0;

        // u_done lands exactly on the expiry cycle: normal completion wins.
        unit_silent = 1'b0;
        unit_lat    = TO;
        sb.push_back('{1, 32'd55, 1'b0});
        set_req(1, 1'b0, 32'd50, 32'd5);
        flag = 1'b0;
        nd   = 0;
        for (int c = 0; c < 40 && nd == 0; c++) begin
            @(negedge CLK);
            if (u_abort) flag = 1'b1;
            if (done[1]) begin
                nd     = 1;
                req[1] = 1'b0;
            end
        end
        check("t5_race_done", nd, 1);
        check("t5_race_no_abort", flag, 0);
`endif

        repeat (4) @(negedge CLK);
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mcycle_sched.md
Name: mcycle_sched

Overview:
Round-robin scheduler that shares one iterative multi-cycle unit (MCycle multiply/divide or FPUnit) between NREQ requesters.
- Each requester uses a level req / one-cycle done handshake.
- The scheduler latches the winner's opcode and operands, pulses the unit's start, and waits for the unit's done.
- It then returns the result to the winner and advances fairness.
- Sits between the execute-stage issue logic (integer and FP requesters) and the shared multi-cycle unit.

Parameters:
NREQ, 2, number of requesters (2..4)
OPW, 1, opcode width passed to the unit
DW, 32, operand/result width
TIMEOUT_CYC, 64, watchdog limit in cycles (used only with MCS_TIMEOUT_EN)

Ports:
CLK  in  1  clock; all state updates on rising edge
Reset  in  1  synchronous, active-high reset
req  in  NREQ  per-requester request level; held until own done
op  in  NREQ*OPW  per-requester opcode; slice i = op[i*OPW +: OPW]
opa  in  NREQ*DW  per-requester operand 1, same slicing
opb  in  NREQ*DW  per-requester operand 2, same slicing
gnt  out  NREQ  one-hot grant, high ISSUE through RESP
done  out  NREQ  one-hot, one-cycle completion pulse
result  out  DW  result; valid only while done is non-zero
err  out  1  one-cycle pulse with done on an aborted operation
spurious  out  1  sticky: u_done seen outside WAIT
u_start  out  1  one-cycle start to the unit
u_op  out  OPW  latched opcode
u_opa  out  DW  latched operand 1
u_opb  out  DW  latched operand 2
u_abort  out  1  one-cycle abort to the unit
u_busy  in  1  unit busy (monitored only)
u_done  in  1  unit completion pulse
u_result  in  DW  unit result, valid with u_done

Behaviour:
- Reset:
  - state=IDLE, rr pointer=0.
  - gnt, done, result, err, spurious, u_start, u_op, u_opa, u_opb, u_abort all 0.
  - Reset mid-operation abandons the job: no done is issued and u_start is not re-issued.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req!=0, pick the first set index scanning from ptr upward with wrap (ptr, ptr+1, ..., NREQ-1, 0, ...).
  - Latch idx, op/opa/opb slices into u_op/u_opa/u_opb, then go to ISSUE.
  - If req==0, stay in IDLE.
- ISSUE:
  - u_start=1 for exactly this cycle; gnt[idx]=1; go to WAIT.
  - u_done during ISSUE is ignored; the unit guarantees at least 1 cycle of latency.
- WAIT:
  - On u_done: result<=u_result, go to RESP.
  - Operands stay stable in u_opa/u_opb for the whole operation.
- RESP:
  - done[idx]=1 and result valid for one cycle; gnt[idx] still high.
  - ptr<=(idx+1) mod NREQ; go to IDLE.
  - The result register holds its value after RESP; consumers must qualify it with done.
- Latency: req sampled in IDLE at cycle t gives u_start at t+1. u_done at cycle d gives done at d+1. Minimum turnaround req to done is 4 cycles.
- Requesters deassert req the cycle after done. A req still high when IDLE is re-entered is treated as a new request.
- A req dropped mid-operation does not cancel it: the operation completes and done pulses.
- Fairness: with all requesters held high, grants rotate 0,1,..,NREQ-1,0. No requester waits more than NREQ-1 operations.
- u_done while IDLE, ISSUE or RESP sets spurious (sticky until Reset) and is otherwise ignored.
- u_busy is not used for sequencing. u_start while u_busy=1 cannot occur by construction.

Optional Feature:
MCS_TIMEOUT_EN
- Defined:
  - A counter clears on WAIT entry and increments each WAIT cycle.
  - When the count reaches TIMEOUT_CYC-1 without u_done: u_abort=1 for one cycle, then go to RESP with result=0, err=1, done[idx]=1.
  - u_done in the same cycle as expiry wins: normal completion, no abort.
- Undefined:
  - No counter; WAIT is unbounded.
  - u_abort and err are tied to 0.

Decomposition:
- Shared package mcycle_pkg: state encoding localparams (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3) and default OPW/DW constants.
- One sub-module, rr_pick: combinational round-robin picker. Inputs req and ptr; outputs grant index and any-valid. Reusable by the hazard unit.

Test Plan:
1. Single req[0], op=1, opa=7, opb=6; unit returns 42 three cycles after start -> u_start at t+1, done=2'b01 with result=42 at u_done+1, gnt[0] high for 5 cycles.
2. req=2'b11 held, unit latency 2 -> grant order 0,1,0,1; each done one-hot; ptr alternates.
3. req[1] dropped during WAIT -> done[1] still pulses; the next grant goes to requester 0.
4. Reset asserted in WAIT, then u_done arrives -> no done, spurious=1, state=IDLE, all outputs 0 except spurious.
5. MCS_TIMEOUT_EN, TIMEOUT_CYC=8, unit silent -> u_abort on the 8th WAIT cycle, then done+err with result=0. With u_done on that same cycle -> normal result, err=0.
6. u_done pulse while IDLE with req=0 -> spurious=1, no done, no state change.
